// File: rtl/serial_inv_theta_key_pkg.sv
// Shared SWAN sizing, inverse theta-key rotation amounts and FSM state encoding.
package swan_pkg;

  localparam int BLOCK_SIZE_DEF  = 256;
  localparam int SIDE_SIZE_DEF   = BLOCK_SIZE_DEF / 2;
  localparam int COLUMN_SIZE_DEF = SIDE_SIZE_DEF / 4;
  localparam int NUM_COLS        = 4;

  // rotation amounts for columns 2, 1, 0 respectively; column 3 is never rotated
  localparam int PA_DEF = 1;
  localparam int PB_DEF = 9;
  localparam int PC_DEF = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_inv_theta_key_if.sv
// Handshake and data bundle between the producer/consumer and the serial inverse theta-key block.
interface serial_inv_theta_key_if #(
  parameter int SIDE_SIZE = swan_pkg::SIDE_SIZE_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic [0:SIDE_SIZE-1] x;
  logic [0:SIDE_SIZE-1] rk;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:SIDE_SIZE-1] y;

  modport master (
    output in_valid, x, rk, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x, rk, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/serial_inv_theta_key_inv_theta_col.sv
// One column of inverse theta-key: XOR with the round key, then rotate left by a runtime amount.
module inv_theta_col
  import swan_pkg::*;
#(
  parameter int COLUMN_SIZE = COLUMN_SIZE_DEF,
  parameter int AW          = $clog2(COLUMN_SIZE)
) (
  input  logic [COLUMN_SIZE-1:0] x_col_i,
  input  logic [COLUMN_SIZE-1:0] rk_col_i,
  input  logic [AW-1:0]          amt_i,
  output logic [COLUMN_SIZE-1:0] y_col_o
);

  logic [COLUMN_SIZE-1:0] mix;

  assign mix = x_col_i ^ rk_col_i;
  // a zero amount shifts the right-hand term out entirely, leaving mix unchanged
  assign y_col_o = (mix << amt_i) | (mix >> (COLUMN_SIZE - amt_i));

endmodule

// File: rtl/serial_inv_theta_key.sv
// Serial inverse theta-key: latches x/rk, recovers one column per cycle, holds y until taken.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for in_valid to latch x and rk
//   RUN   | one column per cycle, order 0..3, written into y
//   DONE  | out_valid high, y held until out_ready
module serial_inv_theta_key
  import swan_pkg::*;
#(
  parameter int BLOCK_SIZE  = BLOCK_SIZE_DEF,
  parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int COLUMN_SIZE = SIDE_SIZE / 4,
  parameter int PA          = PA_DEF,
  parameter int PB          = PB_DEF,
  parameter int PC          = PC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_inv_theta_key_if.slave bus
);

  localparam int AW = $clog2(COLUMN_SIZE);

  if (SIDE_SIZE * 2 != BLOCK_SIZE || COLUMN_SIZE * NUM_COLS != SIDE_SIZE) begin : g_bad_cfg
    $error("serial_inv_theta_key: inconsistent block/side/column sizes");
  end

  state_e                 state_q;
  logic [1:0]             cnt_q;
  logic [COLUMN_SIZE-1:0] x_q  [NUM_COLS];
  logic [COLUMN_SIZE-1:0] rk_q [NUM_COLS];
  logic [COLUMN_SIZE-1:0] y_q  [NUM_COLS];
  logic                   in_ready_q;
  logic                   out_valid_q;

  logic [AW-1:0]          amt_d;
  logic [COLUMN_SIZE-1:0] col_d;

  always_comb begin
    amt_d = '0;
    case (cnt_q)
      2'd0:    amt_d = AW'(PC);
      2'd1:    amt_d = AW'(PB);
      2'd2:    amt_d = AW'(PA);
      default: amt_d = '0;
    endcase
  end

  inv_theta_col #(
    .COLUMN_SIZE (COLUMN_SIZE),
    .AW          (AW)
  ) u_col (
    .x_col_i  (x_q[cnt_q]),
    .rk_col_i (rk_q[cnt_q]),
    .amt_i    (amt_d),
    .y_col_o  (col_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) begin
        x_q[i]  <= '0;
        rk_q[i] <= '0;
        y_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < NUM_COLS; i++) begin
              x_q[i]  <= bus.x[i*COLUMN_SIZE +: COLUMN_SIZE];
              rk_q[i] <= bus.rk[i*COLUMN_SIZE +: COLUMN_SIZE];
            end
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          y_q[cnt_q] <= col_d;
          cnt_q      <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = {y_q[0], y_q[1], y_q[2], y_q[3]};

endmodule

// File: tb/tb_serial_inv_theta_key.sv
// Directed and round-trip checks for serial_inv_theta_key against hand-computed values.
module tb_serial_inv_theta_key;
  import swan_pkg::*;

  localparam int S = SIDE_SIZE_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  serial_inv_theta_key_if #(.SIDE_SIZE(S)) bus ();

  serial_inv_theta_key dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    if (n == 0) return v;
    return (v >> n) | (v << (32 - n));
  endfunction

  // drives one transaction; lat = edges from accept until out_valid seen
  task automatic run_txn(input logic [0:S-1] xv, input logic [0:S-1] rkv,
                         output logic [0:S-1] yv, output int lat, output bit to);
    int n;
    to  = 1'b0;
    lat = 0;
    yv  = '0;
    n   = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin to = 1'b1; return; end
    bus.x = xv; bus.rk = rkv; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin tick(); n++; lat++; end
    if (n >= 20) begin to = 1'b1; return; end
    yv = bus.y;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.y !== '0) begin failures++; $display("FAIL reset_y got=%h exp=0", bus.y); end
  endtask

  task automatic test_zero();
    logic [0:S-1] yv; int lat; bit to;
    run_txn('0, '0, yv, lat, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL zero_timeout got=%b exp=0", to); end
    checks++; if (yv !== '0) begin failures++; $display("FAIL zero_y got=%h exp=0", yv); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL zero_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_vector(input string nm, input logic [0:S-1] xv, input logic [0:S-1] rkv,
                             input logic [0:S-1] expv);
    logic [0:S-1] yv; int lat; bit to;
    run_txn(xv, rkv, yv, lat, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL %s_timeout got=%b exp=0", nm, to); end
    checks++; if (yv !== expv) begin failures++; $display("FAIL %s_y got=%h exp=%h", nm, yv, expv); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL %s_latency got=%0d exp=4", nm, lat); end
  endtask

  task automatic test_column_order();
    logic [0:S-1] xv;
    logic [31:0]  expc [4];
    logic [0:S-1] ycur;
    xv = {32'h80000000, 32'h00000001, 32'h00000001, 32'hFFFFFFFF};
    expc = '{32'h00040000, 32'h00000200, 32'h00000002, 32'hFFFFFFFF};
    bus.x = xv; bus.rk = '0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      ycur = bus.y;
      checks++; if (ycur[c*32 +: 32] !== expc[c]) begin failures++; $display("FAIL order_col%0d got=%h exp=%h", c, ycur[c*32 +: 32], expc[c]); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL order_in_ready_e%0d got=%b exp=0", c + 1, bus.in_ready); end
      checks++; if (bus.out_valid !== (c == 3)) begin failures++; $display("FAIL order_out_valid_e%0d got=%b exp=%b", c + 1, bus.out_valid, (c == 3)); end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_hold();
    logic [0:S-1] expv;
    expv = {32'h00040000, 32'h00000200, 32'h00000002, 32'hFFFFFFFF};
    bus.x = {32'h80000000, 32'h00000001, 32'h00000001, 32'hFFFFFFFF};
    bus.rk = '0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = (k != 1);
      bus.x = {S{1'b1}};
      tick();
      checks++; if (bus.y !== expv) begin failures++; $display("FAIL hold_y_c%0d got=%h exp=%h", k, bus.y, expv); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready_c%0d got=%b exp=0", k, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid_c%0d got=%b exp=1", k, bus.out_valid); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_out_valid got=%b exp=0", bus.out_valid); end
    tick();
    checks++; if (bus.y !== expv) begin failures++; $display("FAIL hold_no_stray_accept got=%h exp=%h", bus.y, expv); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.x = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'h11111111};
    bus.rk = '0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.y !== '0) begin failures++; $display("FAIL midrst_y got=%h exp=0", bus.y); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_out_valid_pulse got=%b exp=0", seen); end
    test_vector("midrst_fresh",
                {32'h80000000, 32'h00000001, 32'h00000001, 32'hFFFFFFFF}, '0,
                {32'h00040000, 32'h00000200, 32'h00000002, 32'hFFFFFFFF});
  endtask

  task automatic test_roundtrip();
    logic [0:S-1] a, rkv, xv, yv;
    logic [31:0]  ac, rc;
    int lat; bit to;
    int rot [4];
    rot = '{PC_DEF, PB_DEF, PA_DEF, 0};
    for (int t = 0; t < 1000; t++) begin
      for (int c = 0; c < 4; c++) begin
        ac = $urandom; rc = $urandom;
        a[c*32 +: 32]   = ac;
        rkv[c*32 +: 32] = rc;
        xv[c*32 +: 32]  = rotr(ac, rot[c]) ^ rc;
      end
      run_txn(xv, rkv, yv, lat, to);
      checks++;
      if (to !== 1'b0 || yv !== a) begin
        failures++;
        $display("FAIL roundtrip_%0d got=%h exp=%h timeout=%b", t, yv, a, to);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.x = '0; bus.rk = '0;
    test_reset();
    test_zero();
    test_vector("vec029", {32'h80000000, 32'h00000001, 32'h00000001, 32'hFFFFFFFF}, '0,
                {32'h00040000, 32'h00000200, 32'h00000002, 32'hFFFFFFFF});
    test_vector("col3", {96'h0, 32'hFFFFFFFF}, {96'h0, 32'hFFFFFFFF}, '0);
    test_vector("rkmix", {32'h00000000, 32'h80000000, 32'h12345678, 32'hA5A5A5A5},
                {32'h00002000, 32'h00000000, 32'h12345679, 32'h5A5A5A5A},
                {32'h00000001, 32'h00000100, 32'h00000002, 32'hFFFFFFFF});
    test_column_order();
    test_hold();
    test_reset_mid();
    test_roundtrip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_inv_theta_key.md
SERIAL_INV_THETA_KEY -- requirements
Module: serial_inv_theta_key

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 256, cipher block width.
REQ-002 SHALL have parameter SIDE_SIZE, default BLOCK_SIZE/2, half-state width.
REQ-003 SHALL have parameter COLUMN_SIZE, default SIDE_SIZE/4, column width.
REQ-004 SHALL have parameters PA, PB, PC, defaults 1, 9, 19, rotation amounts for columns 2, 1, 0.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, x/rk presented.
REQ-008 SHALL have port in_ready, output, 1, block accepts input.
REQ-009 SHALL have port x, input, [0:SIDE_SIZE-1], theta-key output to invert; bit 0 is MSB.
REQ-010 SHALL have port rk, input, [0:SIDE_SIZE-1], round key.
REQ-011 SHALL have port out_valid, output, 1, y holds a result.
REQ-012 SHALL have port out_ready, input, 1, consumer takes y.
REQ-013 SHALL have port y, output, [0:SIDE_SIZE-1], recovered pre-theta half-state.

Function
REQ-014 SHALL split x and rk into columns 0..3, where column i is bits [i*COLUMN_SIZE : (i+1)*COLUMN_SIZE-1].
REQ-015 SHALL compute each output column as: column 3 = x3^rk3; columns 2, 1, 0 = numeric rotate-left of (xi^rki) by PA, PB, PC respectively. This exactly inverts the forward theta-key step (rotate-right, then XOR).
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 in IDLE: in_ready=1; on a clock edge with in_valid=1, SHALL latch x and rk, clear column counter, go to RUN.
REQ-018 in RUN: SHALL process exactly one column per cycle, in order 0,1,2,3, writing it into the y register; 2-bit counter increments each cycle; after column 3 SHALL go to DONE.
REQ-019 in DONE: out_valid=1 and y SHALL be held stable; on an edge with out_ready=1, SHALL return to IDLE.
REQ-020 latency SHALL be: accept at edge E0; columns written at E1..E4; out_valid high from E4 until the handshake.
REQ-021 in_ready SHALL be 0 in RUN and DONE; changes on x, rk, in_valid outside IDLE SHALL be ignored.
REQ-022 out_valid SHALL be 0 in IDLE and RUN; out_ready SHALL be ignored outside DONE.
REQ-023 no accept and release in the same cycle; minimum spacing between accepts SHALL be 6 cycles.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, counter=0, y=0, latched x/rk=0, out_valid=0, in_ready=1 after that edge, from any state.
REQ-025 reset mid-RUN or in DONE SHALL discard the partial or pending result with no out_valid pulse.

Structure
REQ-026 SWAN side/column sizes, PA/PB/PC and the FSM state encoding SHALL live in shared package swan_pkg.
REQ-027 the per-column XOR plus rotate datapath SHALL be one combinational sub-module, inv_theta_col, with a runtime-selected rotate amount indexed by the counter; one instance only.

Verification
REQ-028 x=0, rk=0 -> y=0 at E4, out_valid=1.
REQ-029 rk=0; x columns 0..3 = 80000000, 00000001, 00000001, FFFFFFFF -> y = 00040000, 00000200, 00000002, FFFFFFFF.
REQ-030 x column 3 = FFFFFFFF, rk column 3 = FFFFFFFF, rest 0 -> y column 3 = 0.
REQ-031 random round trip: for 1000 random a and rk, feed the forward theta-key output as x -> y == a.
REQ-032 out_ready held low 3 cycles in DONE -> y stable, in_ready=0, in_valid pulses ignored; release on the 4th cycle -> IDLE next cycle.
REQ-033 rst asserted at E2 of RUN -> y=0, out_valid never asserted, in_ready=1 on the following cycle; a fresh transaction completes correctly.
